// File: rtl/char_overlay_ctl.sv
// char_overlay_ctl: 4-stage char/font ROM sequencer drawing a 16x16 text window on the VGA stream.
// Define CHAR_OVERLAY_BG_EN to fill unset window pixels with BG_COLOR (opaque box).
module char_overlay_ctl #(
  parameter int          X_POS      = 48,
  parameter int          Y_POS      = 64,
  parameter logic [11:0] TEXT_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR   = 12'h008
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        overlay_en,
  output logic [7:0]  char_xy,
  input  logic [6:0]  char_code,
  output logic [10:0] font_addr,
  input  logic [7:0]  char_pixels,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);
  localparam logic [10:0] X_LO = 11'(X_POS);
  localparam logic [10:0] X_HI = 11'(X_POS + 128);
  localparam logic [10:0] Y_LO = 11'(Y_POS);
  localparam logic [10:0] Y_HI = 11'(Y_POS + 256);
  logic        r_en_frame;
  logic [6:0]  w_relx;
  logic [7:0]  w_rely;
  logic        w_in_win;
  logic [37:0] w_pipe_in, r_pipe_d1, r_pipe_d2, r_pipe_d3;
  logic [3:0]  r_line_d1, r_line_d2;
  logic [2:0]  r_bit_d1, r_bit_d2, r_bit_d3;
  logic        r_win_d1, r_win_d2, r_win_d3;
  logic [11:0] w_off_color;
  // only the low bits of the relative coordinates are ever used, so subtract narrow
  assign w_relx = hcount_in[6:0] - X_LO[6:0];
  assign w_rely = vcount_in[7:0] - Y_LO[7:0];
  assign w_in_win = (hcount_in >= X_LO) && (hcount_in < X_HI) && (vcount_in >= Y_LO) &&
                    (vcount_in < Y_HI) && !hblnk_in && !vblnk_in && r_en_frame;
  assign w_pipe_in = {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in, rgb_in};
  assign font_addr = {char_code, r_line_d2};
`ifdef CHAR_OVERLAY_BG_EN
  assign w_off_color = r_win_d3 ? BG_COLOR : r_pipe_d3[11:0];
`else
  logic w_unused;
  assign w_unused = ^BG_COLOR;
  assign w_off_color = r_pipe_d3[11:0];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_frame <= 1'b0;
      char_xy    <= '0;
      r_pipe_d1  <= '0;
      r_pipe_d2  <= '0;
      r_pipe_d3  <= '0;
      r_line_d1  <= '0;
      r_line_d2  <= '0;
      r_bit_d1   <= '0;
      r_bit_d2   <= '0;
      r_bit_d3   <= '0;
      r_win_d1   <= 1'b0;
      r_win_d2   <= 1'b0;
      r_win_d3   <= 1'b0;
      hcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vcount_out <= '0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      if (hcount_in == '0 && vcount_in == '0) r_en_frame <= overlay_en;
      char_xy    <= w_in_win ? {w_relx[6:3], w_rely[7:4]} : 8'h00;
      r_line_d1  <= w_rely[3:0];
      r_bit_d1   <= w_relx[2:0];
      r_win_d1   <= w_in_win;
      r_pipe_d1  <= w_pipe_in;
      r_line_d2  <= r_line_d1;
      r_bit_d2   <= r_bit_d1;
      r_win_d2   <= r_win_d1;
      r_pipe_d2  <= r_pipe_d1;
      r_bit_d3   <= r_bit_d2;
      r_win_d3   <= r_win_d2;
      r_pipe_d3  <= r_pipe_d2;
      {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out} <= r_pipe_d3[37:12];
      rgb_out    <= (r_win_d3 && char_pixels[3'd7 - r_bit_d3]) ? TEXT_COLOR : w_off_color;
    end
  end
endmodule

// File: tb/tb_char_overlay_ctl.sv
// tb_char_overlay_ctl: directed stimulus, per-cycle model comparison and literal pins for char_overlay_ctl.
module tb_char_overlay_ctl;
  localparam logic [11:0] TEXT = 12'hFFF;
  localparam logic [11:0] BG   = 12'h008;
  logic        clk = 0, rst = 1;
  logic [10:0] hcount_in = 0, vcount_in = 0;
  logic        hsync_in = 0, hblnk_in = 0, vsync_in = 0, vblnk_in = 0;
  logic [11:0] rgb_in = 0;
  logic        overlay_en = 0;
  logic [7:0]  char_xy, char_pixels;
  logic [6:0]  char_code;
  logic [10:0] font_addr, hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [7:0]  font_pat = 8'h80;
  int errors = 0, checks = 0, draw_cnt = 0, cyc = 0;
  typedef struct {
    int h, v;
    logic hs, hb, vs, vb, r, win;
    logic [11:0] rgb;
    logic [7:0] pat, cxy;
    int line, bitn;
  } smp_t;
  smp_t hist[$];
  logic m_en = 0;

  always #5 clk = ~clk;

  char_overlay_ctl dut (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
    .overlay_en(overlay_en), .char_xy(char_xy), .char_code(char_code), .font_addr(font_addr),
    .char_pixels(char_pixels), .hcount_out(hcount_out), .hsync_out(hsync_out),
    .hblnk_out(hblnk_out), .vcount_out(vcount_out), .vsync_out(vsync_out),
    .vblnk_out(vblnk_out), .rgb_out(rgb_out)
  );

  function automatic logic [6:0] crom(input logic [7:0] a);
    return a[6:0] ^ {a[7], 6'h15};
  endfunction

  // registered ROM models: char ROM scrambles the address, font ROM returns a settable pattern
  always @(posedge clk) begin
    char_code   <= crom(char_xy);
    char_pixels <= font_pat;
  end

  // window model evaluated on every sampled input
  always @(posedge clk) begin
    smp_t s;
    s.h = int'(hcount_in); s.v = int'(vcount_in);
    s.hs = hsync_in; s.hb = hblnk_in; s.vs = vsync_in; s.vb = vblnk_in;
    s.rgb = rgb_in; s.r = rst; s.pat = font_pat;
    s.win = m_en && s.h >= 48 && s.h < 176 && s.v >= 64 && s.v < 320 && !s.hb && !s.vb;
    s.bitn = (s.h - 48) & 7;
    s.line = (s.v - 64) & 15;
    s.cxy = (!rst && s.win) ? 8'(((s.h - 48) / 8) * 16 + (s.v - 64) / 16) : 8'h00;
    if (rst) m_en = 0;
    else if (s.h == 0 && s.v == 0) m_en = overlay_en;
    hist.push_back(s);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit rst_in(input int a, input int b);
    for (int i = a; i <= b; i++) if (i >= 0 && hist[i].r) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    int k;
    smp_t s;
    logic [7:0] p;
    logic on;
    logic [11:0] e;
    if (cyc >= 4) begin
      k = cyc - 1;
      chk("char_xy", char_xy, hist[k].cxy);
      chk("font_addr", font_addr, {crom(hist[k-1].cxy), rst_in(k-1, k) ? 4'd0 : 4'(hist[k-1].line)});
      if (rst_in(k-3, k)) begin
        chk("timing_rst", {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}, 0);
        chk("rgb_rst", rgb_out, 0);
      end else begin
        s = hist[k-3];
        p = hist[k-1].pat;
        on = s.win && p[7 - s.bitn];
`ifdef CHAR_OVERLAY_BG_EN
        e = on ? TEXT : s.win ? BG : s.rgb;
`else
        e = on ? TEXT : s.rgb;
`endif
        chk("timing", {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out},
            {11'(s.h), s.hs, s.hb, 11'(s.v), s.vs, s.vb});
        chk("rgb", rgb_out, e);
        if (rgb_out == TEXT) draw_cnt++;
      end
    end
  end

  task automatic px(input int h, input int v, input logic [11:0] c, input logic hb = 0, input logic vb = 0);
    hcount_in = 11'(h); vcount_in = 11'(v); rgb_in = c;
    hblnk_in = hb; vblnk_in = vb;
    hsync_in = (h % 16 == 3);
    vsync_in = (v == 1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) px(1000, 1000, 12'h000);
  endtask

  task automatic sweep(input int h0, input int h1, input int v);
    for (int h = h0; h <= h1; h++) px(h, v, 12'h123);
  endtask

  initial begin
    repeat (4) px(5, 5, 12'h111);
    rst = 0;
    overlay_en = 1;
    px(0, 0, 12'h000);
    px(10, 10, 12'h222);
    px(11, 10, 12'h222);
    rst = 1;
    px(60, 70, 12'h333); px(61, 70, 12'h333); px(62, 70, 12'h333);
    chk("rst_rgb", rgb_out, 0);
    chk("rst_hcount", hcount_out, 0);
    chk("rst_char_xy", char_xy, 0);
    rst = 0;
    for (int h = 1; h < 8; h++) begin
      px(h, 1, 12'h0A0);
      if (h == 5) chk("hsync_d3", hsync_out, 0);
      if (h == 6) begin
        chk("hsync_d4", hsync_out, 1);
        chk("hcount_d4", hcount_out, 3);
      end
    end
    px(0, 0, 12'h000);
    px(91, 103, 12'h444);
    chk("addr_char_xy", char_xy, 8'h52);
    px(92, 103, 12'h444);
    chk("addr_font", font_addr, 11'h477);
    idle(4);
    px(48, 64, 12'hABC); px(49, 64, 12'hABC); px(50, 64, 12'hABC); px(51, 64, 12'hABC);
    chk("comp_bit0", rgb_out, TEXT);
    px(52, 64, 12'hABC);
    chk("comp_bit1", rgb_out, 12'hABC);
    idle(4);
    font_pat = 8'hFF;
    idle(4);
    draw_cnt = 0; sweep(47, 176, 64); idle(4);
    chk("sweep_top", draw_cnt, 128);
    draw_cnt = 0; sweep(40, 180, 319); idle(4);
    chk("sweep_last_line", draw_cnt, 128);
    draw_cnt = 0; sweep(40, 180, 320); idle(4);
    chk("sweep_below", draw_cnt, 0);
    draw_cnt = 0;
    for (int h = 60; h < 70; h++) px(h, 100, 12'h321, 1'b1, 1'b0);
    for (int h = 60; h < 70; h++) px(h, 100, 12'h321, 1'b0, 1'b1);
    idle(4);
    chk("blank", draw_cnt, 0);
    overlay_en = 0; px(0, 0, 12'h000);
    overlay_en = 1; draw_cnt = 0; sweep(48, 63, 100); idle(4);
    chk("latch_rise_same", draw_cnt, 0);
    px(0, 0, 12'h000);
    draw_cnt = 0; sweep(48, 63, 100); idle(4);
    chk("latch_rise_next", draw_cnt, 16);
    overlay_en = 0; draw_cnt = 0; sweep(48, 63, 100); idle(4);
    chk("latch_fall_same", draw_cnt, 16);
    px(0, 0, 12'h000);
    draw_cnt = 0; sweep(48, 63, 100); idle(4);
    chk("latch_fall_next", draw_cnt, 0);
    overlay_en = 1; px(0, 0, 12'h000);
    draw_cnt = 0; sweep(48, 55, 100); idle(4);
    rst = 1; px(56, 100, 12'h123); px(57, 100, 12'h123);
    rst = 0; sweep(58, 65, 100); idle(4);
    chk("midrst", draw_cnt, 8);
    px(0, 0, 12'h000);
    draw_cnt = 0; sweep(48, 55, 100); idle(4);
    chk("midrst_next", draw_cnt, 8);
    font_pat = 8'h00;
    idle(4);
    px(48, 64, 12'h5A5); px(49, 64, 12'h5A5); px(50, 64, 12'h5A5); px(51, 64, 12'h5A5);
`ifdef CHAR_OVERLAY_BG_EN
    chk("bg_inside", rgb_out, BG);
`else
    chk("bg_inside", rgb_out, 12'h5A5);
`endif
    px(20, 64, 12'h5A6); px(21, 64, 12'h5A6); px(22, 64, 12'h5A6); px(23, 64, 12'h5A6);
    chk("bg_outside", rgb_out, 12'h5A6);
    idle(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/char_overlay_ctl.md
Name: char_overlay_ctl

Overview:
- Sequences the 16x16 character ROM and the 8x16 font ROM to draw a 16-column x 16-row text window (128x256 px) on the VGA stream.
- Derives char_xy from the incoming VGA counters and forms the font address from the returned char_code.
- Delays VGA timing and rgb so every output is aligned to the fetched pixel.
- Sits between the timing/background stage and the downstream draw stages.

Parameters:
- X_POS, 48, window left edge in pixels (hcount units).
- Y_POS, 64, window top edge in lines (vcount units).
- TEXT_COLOR, 12'hFFF, rgb for set font pixels.
- BG_COLOR, 12'h008, window background (used only with the optional feature).

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- hcount_in  in  11  horizontal counter
- hsync_in  in  1  horizontal sync
- hblnk_in  in  1  horizontal blank
- vcount_in  in  11  vertical counter
- vsync_in  in  1  vertical sync
- vblnk_in  in  1  vertical blank
- rgb_in  in  12  background pixel
- overlay_en  in  1  request to show text; sampled once per frame
- char_xy  out  8  to char ROM: [7:4]=column, [3:0]=row
- char_code  in  7  from char ROM, valid 1 cycle after char_xy
- font_addr  out  11  to font ROM: {char_code, char_line}
- char_pixels  in  8  from font ROM, valid 1 cycle after font_addr; bit 7 is the leftmost pixel
- hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out  out  11/1/1/11/1/1  delayed timing
- rgb_out  out  12  composited pixel

Behaviour:
- Reset: all outputs and pipeline registers are 0; en_frame is 0.
- Frame latch: en_frame <= overlay_en when hcount_in==0 && vcount_in==0. It holds for the whole frame; a mid-frame toggle of overlay_en has no effect until the next frame start.
- Relative coordinates: relx = hcount_in - X_POS, rely = vcount_in - Y_POS, both 11-bit unsigned.
- in_win = (hcount_in >= X_POS) && (hcount_in < X_POS+128) && (vcount_in >= Y_POS) && (vcount_in < Y_POS+256) && !hblnk_in && !vblnk_in && en_frame.
- Stage 1 (edge 1): char_xy <= {relx[6:3], rely[7:4]} when in_win, else 8'h00. Also registers line_d1 = rely[3:0], bit_d1 = relx[2:0], win_d1, timing_d1, rgb_d1.
- Stage 2 (edge 2): the char ROM registers char_code. The block registers line_d2, bit_d2, win_d2, timing_d2, rgb_d2. font_addr = {char_code, line_d2} is combinational from registered signals.
- Stage 3 (edge 3): the font ROM registers char_pixels. The block registers bit_d3, win_d3, timing_d3, rgb_d3.
- Stage 4 (edge 4): rgb_out <= (win_d3 && char_pixels[7-bit_d3]) ? TEXT_COLOR : rgb_d3. Timing outputs <= timing_d3.
- Latency: exactly 4 clk from any input sample to the matching outputs. Timing and rgb share the same delay line.
- Window boundaries:
  - Pixel at X_POS+127 / Y_POS+255 is drawn.
  - X_POS+128 and Y_POS+256 are not drawn.
  - hcount < X_POS is excluded by the compare; relx underflow never reaches char_xy.
- Blanking inside the window range suppresses drawing; rgb_out equals delayed rgb_in.
- Mid-operation reset: the pipeline flushes to 0. Outputs are valid again 4 cycles after rst deasserts. en_frame stays 0 until the next frame start.

Optional Feature:
- Macro: CHAR_OVERLAY_BG_EN.
- Defined: pixels with win_d3=1 and font bit 0 output BG_COLOR, giving an opaque text box.
- Undefined: those pixels output rgb_d3 (transparent), and the BG_COLOR parameter is unused.

Test Plan:
- Reset: assert rst for 3 cycles mid-line -> all outputs 0. After release, hsync_out equals hsync_in delayed by exactly 4 cycles.
- Addressing: X_POS=48, Y_POS=64, en set at frame start, hcount_in=48+8*5+3, vcount_in=64+16*2+7 -> char_xy=8'h52 one cycle later; font_addr={char_code,4'd7} one cycle after that.
- Compositing: font model returns 8'b1000_0000. For the pixel with relx[2:0]=0 -> rgb_out=12'hFFF 4 cycles later; relx[2:0]=1 -> rgb_out=rgb_in delayed.
- Boundaries: sweep hcount 47..176 on line Y_POS -> drawing window exactly hcount 48..175. Line Y_POS+256 -> never drawn.
- Frame latch: overlay_en rises mid-frame -> no text that frame; text appears from pixel (0,0) of the next frame. Same behaviour for falling.
- Optional feature: with CHAR_OVERLAY_BG_EN defined and char_pixels=8'h00 inside the window -> rgb_out=12'h008. Outside the window -> rgb_in passthrough.
